// File: rtl/xor_crc_pkg.sv
// Shared definitions for the serial XOR/LFSR CRC engine.
//   state_t  : frame state encoding (ST_IDLE, ST_SHIFT, ST_FIN)
//   crc_step : reference single-bit Galois LFSR update for widths up to CRC_MAX_W
package xor_crc_pkg;

  localparam int unsigned CRC_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  // One MSB-first bit through the LFSR; the result is masked to 'width' bits.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 d,
    input logic [CRC_MAX_W-1:0] poly,
    input int unsigned          width = CRC_MAX_W
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] mask;
    fb   = crc[width-1] ^ d;
    mask = (width >= CRC_MAX_W) ? '1 : ((CRC_MAX_W'(1) << width) - CRC_MAX_W'(1));
    return ((crc << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/xor_crc_step.sv
// Combinational single-bit Galois LFSR update built from per-bit XOR cells.
//   crc        in  WIDTH : current CRC register
//   d          in  1     : serial data bit
//   crc_next_c out WIDTH : register value after shifting in d
module xor_crc_step
  import xor_crc_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h07)
) (
  input  logic [WIDTH-1:0] crc,
  input  logic             d,
  output logic [WIDTH-1:0] crc_next_c
);

  logic fb;

  // Feedback is the bit falling off the top XORed with the incoming data.
  assign fb = crc[WIDTH-1] ^ d;

  // Bit 0 has no lower neighbour, so it only sees the feedback tap.
  assign crc_next_c[0] = fb & POLY[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_cell
    assign crc_next_c[i] = crc[i-1] ^ (fb & POLY[i]);
  end

endmodule

// File: rtl/xor_crc_engine.sv
// Serial CRC engine: accepts one bit per enabled clock, runs a LEN-bit frame
// through a WIDTH-bit Galois LFSR and reports remainder, match and completion.
//   CLK   in  1        : clock, rising edge
//   RST   in  1        : synchronous active-high reset
//   START in  1        : load INIT, clear count, begin frame (any state)
//   EN    in  1        : D is valid this cycle
//   D     in  1        : serial data bit, MSB-first
//   EXP   in  WIDTH    : expected remainder, sampled with the last bit
//   BUSY  out 1        : frame in progress (includes the FIN cycle)
//   DONE  out 1        : one-cycle completion pulse
//   MATCH out 1        : CRC == EXP at completion, held until START/RST
//   CRC   out WIDTH    : live CRC register
//   CNT   out clog2(LEN+1) : bits accepted in the current frame
module xor_crc_engine
  import xor_crc_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h07),
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int unsigned      LEN   = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       EN,
  input  logic                       D,
  input  logic [WIDTH-1:0]           EXP,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       MATCH,
  output logic [WIDTH-1:0]           CRC,
  output logic [$clog2(LEN+1)-1:0]   CNT
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);

  state_t           state;
  logic [WIDTH-1:0] crc_next_c;
  logic             last_bit_c;

  xor_crc_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc        (CRC),
    .d          (D),
    .crc_next_c (crc_next_c)
  );

  assign last_bit_c = (CNT == CNT_W'(LEN - 1));

  // Frame state machine, bit counter and match register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      CRC   <= INIT;
      CNT   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      MATCH <= 1'b0;
    end else begin
      DONE <= 1'b0;
      // START takes priority over EN, so D is discarded on a restart.
      if (START) begin
        state <= ST_SHIFT;
        CRC   <= INIT;
        CNT   <= '0;
        MATCH <= 1'b0;
        BUSY  <= 1'b1;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (EN) begin
              CRC <= crc_next_c;
              CNT <= CNT + CNT_W'(1);
              if (last_bit_c) begin
                MATCH <= (crc_next_c == EXP);
                DONE  <= 1'b1;
                state <= ST_FIN;
              end
            end
          end
          ST_FIN: begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
